// File: rtl/alu_output_stage.sv
// ---------------------------------------------------------------------------
// alu_output_stage
//
// Registered output stage behind the ALU's per-bit result-select mux array.
// It captures the selected result and the adder's carry/overflow, derives
// the condition flags {Z,N,C,V}, and holds them in a two-entry skid buffer
// with a valid/ready handshake toward writeback. The architectural status
// register, read by branch logic, is loaded with the flags of each entry
// as writeback takes it.
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset       in   asynchronous active-low reset
//   Hyrja       in   WIDTH-bit result from the mux array
//   S           in   operation that drove the mux array (00 AND, 01 OR,
//                    10 ADD, 11 SUB)
//   CarryIn     in   adder carry-out (for SUB, 1 means no borrow)
//   OverflowIn  in   adder signed overflow
//   HyrjaValid  in   upstream offers a result this cycle
//   HyrjaReady  out  stage accepts a result this cycle (registered)
//   Dalja       out  buffered result toward writeback
//   DaljaFlags  out  flags of the Dalja entry, {Z,N,C,V}
//   DaljaValid  out  Dalja/DaljaFlags valid
//   DaljaReady  in   writeback takes the entry this cycle
//   Status      out  architectural status register, {Z,N,C,V}
// ---------------------------------------------------------------------------
module alu_output_stage #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Hyrja,
    input  logic [1:0]       S,
    input  logic             CarryIn,
    input  logic             OverflowIn,
    input  logic             HyrjaValid,
    output logic             HyrjaReady,
    output logic [WIDTH-1:0] Dalja,
    output logic [3:0]       DaljaFlags,
    output logic             DaljaValid,
    input  logic             DaljaReady,
    output logic [3:0]       Status
);

    // Flags for a freshly selected result. Carry and overflow only mean
    // something for the adder paths (S[1]=1); logic ops report them as 0.
    function automatic logic [3:0] calc_flags(
        input logic signed [WIDTH-1:0] res,
        input logic [1:0]              op,
        input logic                    carry,
        input logic                    ovf
    );
        logic zero;
        logic neg;
        zero = (res == '0);
        neg  = res[WIDTH-1];
        return {zero, neg, op[1] & carry, op[1] & ovf};
    endfunction

    // Stage p0: incoming result and its flags (combinational, mux output)
    logic signed [WIDTH-1:0] data_p0;
    logic [3:0]              flags_p0;
    logic                    vld_p0;

    assign data_p0  = Hyrja;
    assign flags_p0 = calc_flags(data_p0, S, CarryIn, OverflowIn);
    assign vld_p0   = HyrjaValid;

    // Stage p1: main entry (drives the outputs) and skid entry
    logic signed [WIDTH-1:0] main_data_p1;
    logic [3:0]              main_flags_p1;
    logic                    main_vld_p1;
    logic signed [WIDTH-1:0] skid_data_p1;
    logic [3:0]              skid_flags_p1;
    logic                    skid_vld_p1;
    logic [3:0]              status_p1;

    logic accept;
    logic drain;

    // Ready depends only on the skid register, so no input reaches an output
    // combinationally. With the skid full the main entry is full as well.
    assign accept = vld_p0 & ~skid_vld_p1;
    assign drain  = main_vld_p1 & DaljaReady;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            main_data_p1  <= '0;
            main_flags_p1 <= '0;
            main_vld_p1   <= 1'b0;
            skid_data_p1  <= '0;
            skid_flags_p1 <= '0;
            skid_vld_p1   <= 1'b0;
            status_p1     <= '0;
        end else begin
            if (drain) begin
                status_p1 <= main_flags_p1;
            end

            if (!main_vld_p1 || drain) begin
                // Main slot is free at this edge. The skid entry is older
                // than anything arriving now, so it goes first; an accept
                // cannot coincide with a full skid because ready is low.
                if (skid_vld_p1) begin
                    main_data_p1  <= skid_data_p1;
                    main_flags_p1 <= skid_flags_p1;
                    main_vld_p1   <= 1'b1;
                    skid_vld_p1   <= 1'b0;
                end else if (accept) begin
                    main_data_p1  <= data_p0;
                    main_flags_p1 <= flags_p0;
                    main_vld_p1   <= 1'b1;
                end else begin
                    // Data is left as is so Dalja holds its last value.
                    main_vld_p1   <= 1'b0;
                end
            end else if (accept) begin
                // Main is stalled: park the new entry in the skid slot.
                skid_data_p1  <= data_p0;
                skid_flags_p1 <= flags_p0;
                skid_vld_p1   <= 1'b1;
            end
        end
    end

    assign HyrjaReady = ~skid_vld_p1;
    assign Dalja      = main_data_p1;
    assign DaljaFlags = main_flags_p1;
    assign DaljaValid = main_vld_p1;
    assign Status     = status_p1;

endmodule

// File: doc/alu_output_stage.md
Name: alu_output_stage

Overview:
- Registered output stage directly downstream of the per-bit Mux4ne1 result-select array of the 24-bit ALU.
- Captures the selected 24-bit result together with the adder's carry/overflow, computes condition flags, and buffers them in a 2-entry skid buffer with a valid/ready handshake toward writeback.
- Maintains the architectural status register (Z, N, C, V) consumed by branch logic.

Parameters:
- WIDTH, 24, datapath width; must match the mux array width.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Hyrja  input  WIDTH  result bits from the mux array.
- S  input  2  operation select that drove the mux array: 00 AND, 01 OR, 10 ADD, 11 SUB.
- CarryIn  input  1  adder/subtractor carry-out. For SUB, 1 means no borrow.
- OverflowIn  input  1  adder/subtractor signed overflow.
- HyrjaValid  input  1  upstream presents a valid result this cycle.
- HyrjaReady  output  1  stage can accept a result this cycle.
- Dalja  output  WIDTH  buffered result toward writeback.
- DaljaFlags  output  4  flags of the Dalja entry, ordered {Z,N,C,V}.
- DaljaValid  output  1  Dalja/DaljaFlags valid.
- DaljaReady  input  1  writeback accepts this cycle.
- Status  output  4  architectural status register, ordered {Z,N,C,V}.

Behaviour:
- Reset asserted (Reset=0), asynchronous:
  - Dalja=0, DaljaFlags=0, DaljaValid=0, Status=0.
  - Both buffer entries marked empty.
  - HyrjaReady=1.
- Accept: occurs on a rising edge with HyrjaValid=1 and HyrjaReady=1. Data and flags are ignored when no accept occurs.
- Drain: occurs on a rising edge with DaljaValid=1 and DaljaReady=1.
- Flag computation at accept, from Hyrja:
  - Z = (Hyrja == 0).
  - N = Hyrja[WIDTH-1].
  - C = CarryIn and V = OverflowIn when S[1]=1; C = V = 0 when S[1]=0.
- Buffer: main entry (drives Dalja/DaljaFlags) plus one skid entry. No combinational path from any input to any output.
- Latency: 1 cycle. An entry accepted at edge k is visible with DaljaValid=1 after edge k, provided the main entry is empty or draining at edge k.
- Throughput: 1 accept per cycle sustained while DaljaReady=1.
- Per-edge rules:
  - Main empty, or main draining with skid empty: accepted entry loads main.
  - Main full, not draining, with accept: accepted entry loads skid; HyrjaReady goes 0 on the next cycle.
  - Main draining with skid full: skid moves to main; skid becomes empty; HyrjaReady returns to 1 on the next cycle.
  - Main draining with nothing to load: DaljaValid goes 0; Dalja holds its last value.
- HyrjaReady is registered: HyrjaReady = skid empty.
- FIFO order is strictly preserved; no entry is dropped or duplicated.
- Status updates only on a drain, to the DaljaFlags value of the departing entry. Status holds otherwise.
- Handshake stability: DaljaValid and Dalja stay stable until drained. DaljaReady may toggle freely.
- Reset mid-operation: buffered entries are discarded and Status is cleared. Accept resumes on the first edge after reset is released.

Test Plan:
- Reset, then S=10, Hyrja=24'h000000, CarryIn=1, OverflowIn=0, single beat, DaljaReady=1 -> next cycle Dalja=0, DaljaFlags=4'b1010, DaljaValid=1; after drain Status=4'b1010.
- S=01, Hyrja=24'h800001, CarryIn=1, OverflowIn=1 -> DaljaFlags=4'b0100; C and V are masked for logic ops.
- DaljaReady=0, push A=24'h000011 then B=24'h000022 -> HyrjaReady=0 after B is accepted; raise DaljaReady -> outputs A then B on consecutive cycles; HyrjaReady returns to 1.
- Stream 8 results (values 1..8, S=10) with DaljaReady=1 -> 8 outputs on consecutive cycles, in order; Status equals the flags of value 8.
- Random DaljaReady/HyrjaValid over 1000 cycles vs. a scoreboard -> zero loss, zero duplication, order preserved; DaljaValid/Dalja never change while stalled.
- Reset pulsed while both entries are full -> DaljaValid=0, Status=0, HyrjaReady=1 immediately (asynchronous, no clock edge required).
